lna_bias_sequencer: RTL and testbench

Multi-channel LNA bias supply controller: drives one PWM charge-pump pair (negative gate rail, positive drain rail) per channel and sequences them safely. Gate bias comes up and settles before drain, and drain comes down before gate. Channels power up one after another, soft-start ramps limit inrush, and per-channel over-current inputs force an immediate shutdown. Sits beside the 100 MHz clock generator and replaces the single fixed V+/V- generator used for LNA power.

---
 rtl/lna_bias_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_lna_bias_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lna_bias_sequencer.sv
// lna_bias_sequencer: per-channel LNA gate/drain bias PWM sequencer.
// Gate (negative) rail comes up and settles before the drain (positive) rail.
// Drain comes down before gate. Channels power up in index order.
// Over-current forces an immediate per-channel shutdown.
// Optional feature macro: LNA_BIAS_SOFT_RAMP_EN. When it is defined, duties ramp
// 1 LSB per ramp tick. When it is undefined, duties jump straight to their goal.
module lna_bias_sequencer #(
    parameter int CHANNELS         = 2,
    parameter int PWM_BITS         = 8,
    parameter int RAMP_STEP_CYCLES = 256,
    parameter int SETTLE_CYCLES    = 1024
) (
    input  logic                         Clock100Mhz,
    input  logic                         Reset,
    input  logic                         Enable,
    input  logic [CHANNELS*PWM_BITS-1:0] VminusTarget,
    input  logic [CHANNELS*PWM_BITS-1:0] VplusTarget,
    input  logic [CHANNELS-1:0]          OverCurrent,
    output logic [CHANNELS-1:0]          VminusPwm,
    output logic [CHANNELS-1:0]          VplusPwm,
    output logic [CHANNELS-1:0]          PowerGood,
    output logic [CHANNELS-1:0]          FaultFlag,
    output logic                         Busy
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef logic [PWM_BITS-1:0] duty_t;
    typedef enum logic [2:0] {
        OFF, NEG_UP, NEG_SETTLE, POS_UP, ON, POS_DOWN, NEG_DOWN, FAULT
    } state_t;

    state_t        st_q     [CHANNELS];
    state_t        st_d     [CHANNELS];
    duty_t         vm_q     [CHANNELS];
    duty_t         vm_d     [CHANNELS];
    duty_t         vp_q     [CHANNELS];
    duty_t         vp_d     [CHANNELS];
    duty_t         vm_app   [CHANNELS];
    duty_t         vp_app   [CHANNELS];
    duty_t         vm_tgt   [CHANNELS];
    duty_t         vp_tgt   [CHANNELS];
    logic [SW-1:0] settle_q [CHANNELS];
    logic [SW-1:0] settle_d [CHANNELS];
    duty_t         pwm_cnt;
    logic          wrap;
    logic          tick;
    logic          busy_d;

    assign wrap = (pwm_cnt == '1);

`ifdef LNA_BIAS_SOFT_RAMP_EN
    localparam int TW = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
    logic [TW-1:0] tick_cnt;

    // Shared ramp timebase: one tick every RAMP_STEP_CYCLES clocks.
    always_ff @(posedge Clock100Mhz or posedge Reset) begin
        if (Reset)     tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end
    assign tick = (tick_cnt == TW'(RAMP_STEP_CYCLES - 1));
`else
    assign tick = 1'b1;
`endif

    // Next working duty: 1 LSB toward goal per tick, clamped at the goal.
    function automatic duty_t next_duty(input duty_t cur, input duty_t goal, input logic tk);
`ifdef LNA_BIAS_SOFT_RAMP_EN
        if (!tk || cur == goal) return cur;
        return (cur < goal) ? cur + 1'b1 : cur - 1'b1;
`else
        return tk ? goal : cur;
`endif
    endfunction

    // Unpack per-channel duty targets.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            vm_tgt[k] = VminusTarget[k*PWM_BITS +: PWM_BITS];
            vp_tgt[k] = VplusTarget[k*PWM_BITS +: PWM_BITS];
        end
    end

    // Per-channel sequencing FSM: next state, working duties and settle count.
    always_comb begin
        busy_d = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            st_d[k]     = st_q[k];
            vm_d[k]     = vm_q[k];
            vp_d[k]     = vp_q[k];
            settle_d[k] = settle_q[k];
            case (st_q[k])
                OFF: begin
                    if (Enable && ((k == 0) || PowerGood[(k == 0) ? 0 : k - 1])) begin
                        st_d[k] = NEG_UP;
                        vm_d[k] = next_duty(vm_q[k], vm_tgt[k], tick);
                    end
                end
                NEG_UP: begin
                    if (!Enable) st_d[k] = NEG_DOWN;
                    else if (vm_q[k] == vm_tgt[k]) begin
                        st_d[k]     = NEG_SETTLE;
                        settle_d[k] = SW'(SETTLE_CYCLES - 1);
                    end else vm_d[k] = next_duty(vm_q[k], vm_tgt[k], tick);
                end
                NEG_SETTLE: begin
                    if (!Enable) st_d[k] = NEG_DOWN;
                    else if (settle_q[k] == '0) begin
                        st_d[k] = POS_UP;
                        vp_d[k] = next_duty(vp_q[k], vp_tgt[k], tick);
                    end else settle_d[k] = settle_q[k] - 1'b1;
                end
                POS_UP: begin
                    if (!Enable) st_d[k] = POS_DOWN;
                    else if (vp_q[k] == vp_tgt[k]) st_d[k] = ON;
                    else vp_d[k] = next_duty(vp_q[k], vp_tgt[k], tick);
                end
                ON: begin
                    if (!Enable) st_d[k] = POS_DOWN;
                    else begin
                        vm_d[k] = next_duty(vm_q[k], vm_tgt[k], tick);
                        vp_d[k] = next_duty(vp_q[k], vp_tgt[k], tick);
                    end
                end
                POS_DOWN: begin
                    if (vp_q[k] == '0) st_d[k] = NEG_DOWN;
                    else vp_d[k] = next_duty(vp_q[k], '0, tick);
                end
                NEG_DOWN: begin
                    if (vm_q[k] == '0) st_d[k] = OFF;
                    else vm_d[k] = next_duty(vm_q[k], '0, tick);
                end
                FAULT: begin
                    vm_d[k] = '0;
                    vp_d[k] = '0;
                    if (!Enable && !OverCurrent[k]) st_d[k] = OFF;
                end
                default: st_d[k] = OFF;
            endcase
            // Over-current overrides everything and bypasses the ramp.
            if (OverCurrent[k] && st_q[k] != OFF) begin
                st_d[k] = FAULT;
                vm_d[k] = '0;
                vp_d[k] = '0;
            end
            if (st_d[k] == NEG_UP || st_d[k] == NEG_SETTLE || st_d[k] == POS_UP ||
                st_d[k] == POS_DOWN || st_d[k] == NEG_DOWN)
                busy_d = 1'b1;
        end
    end

    // State, duties, PWM counter and registered status/pin outputs.
    always_ff @(posedge Clock100Mhz or posedge Reset) begin
        if (Reset) begin
            pwm_cnt   <= '0;
            VminusPwm <= '0;
            VplusPwm  <= '0;
            PowerGood <= '0;
            FaultFlag <= '0;
            Busy      <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                st_q[k]     <= OFF;
                vm_q[k]     <= '0;
                vp_q[k]     <= '0;
                vm_app[k]   <= '0;
                vp_app[k]   <= '0;
                settle_q[k] <= '0;
            end
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            Busy    <= busy_d;
            for (int k = 0; k < CHANNELS; k++) begin
                st_q[k]      <= st_d[k];
                vm_q[k]      <= vm_d[k];
                vp_q[k]      <= vp_d[k];
                settle_q[k]  <= settle_d[k];
                // Applied duty only changes at the period boundary.
                if (wrap) begin
                    vm_app[k] <= vm_d[k];
                    vp_app[k] <= vp_d[k];
                end
                VminusPwm[k] <= (pwm_cnt < vm_app[k]);
                VplusPwm[k]  <= (pwm_cnt < vp_app[k]);
                PowerGood[k] <= (st_d[k] == ON);
                FaultFlag[k] <= (st_d[k] == FAULT);
            end
        end
    end
endmodule

// File: tb/tb_lna_bias_sequencer.sv
// Directed testbench for lna_bias_sequencer (CHANNELS=2, PWM_BITS=4, RAMP=4, SETTLE=8).
module tb_lna_bias_sequencer;
`ifdef LNA_BIAS_SOFT_RAMP_EN
    localparam bit RAMP = 1'b1;
    localparam int EXP_VP_STEPS = 5;
    localparam int EXP_VM_STEPS = 3;
`else
    localparam bit RAMP = 1'b0;
    localparam int EXP_VP_STEPS = 1;
    localparam int EXP_VM_STEPS = 1;
`endif
    localparam int LAT = 53;  // (3+1)*4 + 8 + (5+1)*4 + 3 plus sampling slack

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] vmt = 8'h33;
    logic [7:0] vpt = 8'h55;
    logic [1:0] oc = 2'b00;
    logic [1:0] vm_pwm, vp_pwm, pg, ff;
    logic       busy;
    int         passed = 0;
    int         total = 0;

    lna_bias_sequencer #(.CHANNELS(2), .PWM_BITS(4), .RAMP_STEP_CYCLES(4), .SETTLE_CYCLES(8)) dut (
        .Clock100Mhz(clk), .Reset(rst), .Enable(en), .VminusTarget(vmt), .VplusTarget(vpt),
        .OverCurrent(oc), .VminusPwm(vm_pwm), .VplusPwm(vp_pwm), .PowerGood(pg),
        .FaultFlag(ff), .Busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Count pin-high clocks over one 16-clock PWM period.
    task automatic measure(input int ch, input bit plus, output int n);
        n = 0;
        repeat (16) begin
            @(negedge clk);
            n += plus ? int'(vp_pwm[ch]) : int'(vm_pwm[ch]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; oc = 2'b00;
        repeat (3) @(negedge clk);
        total++;
        if ({vm_pwm, vp_pwm, pg, ff, busy} !== 9'd0) $display("FAIL reset_held: got %b expected 0", {vm_pwm, vp_pwm, pg, ff, busy});
        else passed++;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if ({vm_pwm, vp_pwm, pg, ff, busy} !== 9'd0) $display("FAIL idle_after_reset: got %b expected 0", {vm_pwm, vp_pwm, pg, ff, busy});
        else passed++;
    endtask

    task automatic test_power_up();
        int t = 0, t_vm0 = -1, t_vp0 = -1, t_pg0 = -1, t_pg1 = -1, early1 = 0, n;
        bit ok;
        en = 1'b1;
        while (t < 300 && t_pg1 < 0) begin
            @(negedge clk); t++;
            if (vm_pwm[0] && t_vm0 < 0) t_vm0 = t;
            if (vp_pwm[0] && t_vp0 < 0) t_vp0 = t;
            if (!pg[0] && (vm_pwm[1] || vp_pwm[1])) early1++;
            if (pg[0] && t_pg0 < 0) t_pg0 = t;
            if (pg[1] && t_pg1 < 0) t_pg1 = t;
        end
        total++;
        if (t_pg0 < 1 || t_pg0 > LAT) $display("FAIL pg0_latency: got %0d expected 1..%0d", t_pg0, LAT);
        else passed++;
        ok = RAMP ? (t_vm0 > 0 && t_vp0 > t_vm0) : (t_vm0 > 0 && t_vp0 >= t_vm0);
        total++;
        if (!ok) $display("FAIL vm_before_vp: got vm@%0d vp@%0d expected vm first", t_vm0, t_vp0);
        else passed++;
        total++;
        if (early1 != 0) $display("FAIL ch1_waits: got %0d early clocks expected 0", early1);
        else passed++;
        total++;
        if (t_pg1 <= t_pg0 || t_pg1 - t_pg0 > LAT) $display("FAIL pg1_after_pg0: got pg0@%0d pg1@%0d expected pg1 within %0d after", t_pg0, t_pg1, LAT);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL busy_idle: got %b expected 0", busy);
        else passed++;
        repeat (20) @(negedge clk);
        measure(0, 1'b0, n); total++;
        if (n != 3) $display("FAIL duty_vm0: got %0d expected 3", n); else passed++;
        measure(0, 1'b1, n); total++;
        if (n != 5) $display("FAIL duty_vp0: got %0d expected 5", n); else passed++;
        measure(1, 1'b0, n); total++;
        if (n != 3) $display("FAIL duty_vm1: got %0d expected 3", n); else passed++;
        measure(1, 1'b1, n); total++;
        if (n != 5) $display("FAIL duty_vp1: got %0d expected 5", n); else passed++;
    endtask

    task automatic test_power_down();
        int pv = 5, pm = 3, vp_steps = 0, vm_steps = 0, bad = 0, vm_early = 0, t = 0, cv, cm;
        en = 1'b0;
        @(negedge clk);
        total++;
        if (pg !== 2'b00) $display("FAIL pg_drop: got %b expected 00", pg); else passed++;
        while (t < 200 && !(int'(dut.st_q[0]) == 0 && int'(dut.st_q[1]) == 0)) begin
            cv = int'(dut.vp_q[0]); cm = int'(dut.vm_q[0]);
            if (cv != pv) begin vp_steps++; if (RAMP && pv - cv != 1) bad++; end
            if (cm != pm) begin vm_steps++; if (cv != 0) vm_early++; if (RAMP && pm - cm != 1) bad++; end
            pv = cv; pm = cm;
            @(negedge clk); t++;
        end
        total++;
        if (t >= 200) $display("FAIL down_done: got timeout expected OFF"); else passed++;
        total++;
        if (vp_steps != EXP_VP_STEPS) $display("FAIL vp_steps: got %0d expected %0d", vp_steps, EXP_VP_STEPS); else passed++;
        total++;
        if (vm_steps != EXP_VM_STEPS) $display("FAIL vm_steps: got %0d expected %0d", vm_steps, EXP_VM_STEPS); else passed++;
        total++;
        if (bad != 0) $display("FAIL step_size: got %0d bad steps expected 0", bad); else passed++;
        total++;
        if (vm_early != 0) $display("FAIL vp_before_vm: got %0d early vm moves expected 0", vm_early); else passed++;
        repeat (20) @(negedge clk);
        total++;
        if ({vm_pwm, vp_pwm, busy} !== 5'd0) $display("FAIL pins_idle: got %b expected 0", {vm_pwm, vp_pwm, busy}); else passed++;
    endtask

    task automatic test_fault();
        int t = 0, n;
        en = 1'b1;
        while (t < 300 && int'(dut.st_q[1]) != 3) begin @(negedge clk); t++; end
        total++;
        if (t >= 300) $display("FAIL ch1_posup_reached: got timeout expected POS_UP"); else passed++;
        oc[1] = 1'b1;
        @(negedge clk);
        oc[1] = 1'b0;
        total++;
        if (ff !== 2'b10) $display("FAIL faultflag_set: got %b expected 10", ff); else passed++;
        repeat (17) @(negedge clk);
        measure(1, 1'b0, n); total++;
        if (n != 0) $display("FAIL fault_vm1_low: got %0d expected 0", n); else passed++;
        measure(1, 1'b1, n); total++;
        if (n != 0) $display("FAIL fault_vp1_low: got %0d expected 0", n); else passed++;
        total++;
        if (pg !== 2'b01) $display("FAIL ch0_stays_on: got %b expected 01", pg); else passed++;
        en = 1'b1;
        repeat (60) @(negedge clk);
        total++;
        if ({ff[1], pg[1], vm_pwm[1], vp_pwm[1]} !== 4'b1000) $display("FAIL no_restart: got %b expected 1000", {ff[1], pg[1], vm_pwm[1], vp_pwm[1]}); else passed++;
        en = 1'b0;
        @(negedge clk);
        total++;
        if (ff !== 2'b00) $display("FAIL faultflag_clear: got %b expected 00", ff); else passed++;
        repeat (80) @(negedge clk);
        total++;
        if ({pg, busy, vm_pwm, vp_pwm} !== 7'd0) $display("FAIL fault_cleanup: got %b expected 0", {pg, busy, vm_pwm, vp_pwm}); else passed++;
    endtask

    task automatic test_abort();
        int t = 0, vp_seen = 0, illegal = 0, prev = 6, cur;
        bit saw_off = 1'b0, restarted = 1'b0;
        en = 1'b1;
        while (t < 200 && int'(dut.st_q[0]) != 2) begin @(negedge clk); t++; if (vp_pwm[0]) vp_seen++; end
        total++;
        if (t >= 200) $display("FAIL abort_settle_reached: got timeout expected NEG_SETTLE"); else passed++;
        en = 1'b0;
        @(negedge clk);
        total++;
        if (int'(dut.st_q[0]) != 6) $display("FAIL abort_neg_down: got %0d expected 6", int'(dut.st_q[0])); else passed++;
        en = 1'b1;
        t = 0;
        while (t < 200 && !restarted) begin
            @(negedge clk); t++;
            if (vp_pwm[0]) vp_seen++;
            cur = int'(dut.st_q[0]);
            if (prev == 6 && cur != 6 && cur != 0) illegal++;
            if (cur == 0) saw_off = 1'b1;
            if (cur == 1 && saw_off) restarted = 1'b1;
            prev = cur;
        end
        total++;
        if (vp_seen != 0) $display("FAIL abort_no_vp: got %0d high clocks expected 0", vp_seen); else passed++;
        total++;
        if (illegal != 0) $display("FAIL abort_ignore_en: got %0d illegal exits expected 0", illegal); else passed++;
        total++;
        if (!restarted) $display("FAIL abort_restart: got %0d expected 1", restarted); else passed++;
        en = 1'b0;
        repeat (100) @(negedge clk);
        total++;
        if (int'(dut.st_q[0]) != 0 || busy !== 1'b0) $display("FAIL abort_cleanup: got state %0d busy %b expected 0 0", int'(dut.st_q[0]), busy); else passed++;
    endtask

    task automatic test_async_reset();
        int t = 0, n;
        en = 1'b1;
        while (t < 300 && pg !== 2'b11) begin @(negedge clk); t++; end
        total++;
        if (t >= 300) $display("FAIL ar_on: got timeout expected both ON"); else passed++;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({vm_pwm, vp_pwm} !== 4'd0) $display("FAIL ar_pins: got %b expected 0", {vm_pwm, vp_pwm}); else passed++;
        total++;
        if ({pg, ff, busy} !== 5'd0) $display("FAIL ar_flags: got %b expected 0", {pg, ff, busy}); else passed++;
        total++;
        if (int'(dut.st_q[0]) != 0 || int'(dut.st_q[1]) != 0) $display("FAIL ar_state: got %0d/%0d expected 0/0", int'(dut.st_q[0]), int'(dut.st_q[1])); else passed++;
        @(negedge clk);
        rst = 1'b0;
`ifndef LNA_BIAS_SOFT_RAMP_EN
        t = 0;
        while (t < 200 && int'(dut.st_q[0]) != 3) begin @(negedge clk); t++; end
        t = 0;
        while (t < 20 && int'(dut.pwm_cnt) != 0) begin @(negedge clk); t++; end
        measure(0, 1'b1, n); total++;
        if (n != 5) $display("FAIL noramp_first_period: got %0d expected 5", n); else passed++;
`endif
        t = 0;
        while (t < 300 && pg[0] !== 1'b1) begin @(negedge clk); t++; end
        total++;
        if (t >= 300) $display("FAIL ar_repower: got timeout expected PowerGood[0]"); else passed++;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_power_down();
        test_fault();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
